// File: rtl/adc_scan_pkg.sv
// Shared types and helpers for the multiplexed ramp/SAR scan engine.
package adc_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_MUX_SETTLE = 3'd1,
        ST_SET_CODE   = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_DECIDE     = 3'd4,
        ST_DONE       = 3'd5
    } state_e;

    localparam logic MODE_RAMP = 1'b0;
    localparam logic MODE_SAR  = 1'b1;

    // Width needed to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_scan_engine_cmp_sync.sv
// Synchroniser for the asynchronous comparator output; flushes to 0 on reset.
module cmp_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift left: bit 0 takes the raw input, the top bit is the synchronised output.
    always_comb begin
        sync_d = STAGES'({sync_q, din});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/adc_scan_engine.sv
// Time-multiplexed ramp/SAR converter: one DAC and comparator scanned across NUM_CH mux inputs.
module adc_scan_engine
    import adc_scan_pkg::*;
#(
    parameter int DAC_WIDTH         = 8,
    parameter int NUM_CH            = 2,
    parameter int SETTLE_CYCLES     = 1000,
    parameter int MUX_SETTLE_CYCLES = 2000,
    parameter int SYNC_STAGES       = 2,
    localparam int CH_W             = clog2_min1(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_CH-1:0]    ch_enable,
    input  logic [NUM_CH-1:0]    sar_mode,
    input  logic                 compare,
    output logic [DAC_WIDTH-1:0] dac_code,
    output logic [CH_W-1:0]      ch_sel,
    output logic [DAC_WIDTH-1:0] result_data,
    output logic [CH_W-1:0]      result_ch,
    output logic                 result_valid,
    output logic                 overrange,
    output logic                 busy
);

    localparam int unsigned NCH = NUM_CH;
    localparam int CNT_MAX = (SETTLE_CYCLES > MUX_SETTLE_CYCLES) ? SETTLE_CYCLES : MUX_SETTLE_CYCLES;
    localparam int CNT_W   = clog2_min1(CNT_MAX);
    localparam int BIT_W   = clog2_min1(DAC_WIDTH);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DAC_WIDTH-1:0] dac_code_q, dac_code_d;
    logic [DAC_WIDTH-1:0] acc_q, acc_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 first_q, first_d;
    logic                 mode_q, mode_d;
    logic [CH_W-1:0]      ch_sel_q, ch_sel_d;
    logic [CH_W-1:0]      ptr_q, ptr_d;
    logic [DAC_WIDTH-1:0] result_data_q, result_data_d;
    logic [CH_W-1:0]      result_ch_q, result_ch_d;
    logic                 overrange_q, overrange_d;
    logic                 result_valid_q, result_valid_d;

    logic                 cmp_s;
    logic [CH_W-1:0]      pick_ch;
    logic                 pick_mode;

    cmp_sync #(
        .STAGES (SYNC_STAGES)
    ) u_cmp_sync (
        .clk   (clk),
        .reset (reset),
        .din   (compare),
        .dout  (cmp_s)
    );

    // Round-robin: first enabled channel at or after the scan pointer.
    always_comb begin
        logic        found;
        int unsigned idx;
        found   = 1'b0;
        pick_ch = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = (32'(ptr_q) + i) % NCH;
            if (!found && |(ch_enable & (NUM_CH'(1) << idx))) begin
                found   = 1'b1;
                pick_ch = CH_W'(idx);
            end
        end
        pick_mode = |(sar_mode & (NUM_CH'(1) << pick_ch));
    end

    always_comb begin
        logic                 fin;
        logic [DAC_WIDTH-1:0] fin_data;
        logic                 fin_ovr;
        logic [DAC_WIDTH-1:0] acc_next;

        state_d        = state_q;
        cnt_d          = cnt_q;
        dac_code_d     = dac_code_q;
        acc_d          = acc_q;
        bit_d          = bit_q;
        first_d        = first_q;
        mode_d         = mode_q;
        ch_sel_d       = ch_sel_q;
        ptr_d          = ptr_q;
        result_data_d  = result_data_q;
        result_ch_d    = result_ch_q;
        overrange_d    = overrange_q;
        result_valid_d = 1'b0;
        fin            = 1'b0;
        fin_data       = '0;
        fin_ovr        = 1'b0;
        acc_next       = acc_q;

        case (state_q)
            ST_IDLE: begin
                if (enable && |ch_enable) begin
                    mode_d  = pick_mode;
                    acc_d   = '0;
                    bit_d   = BIT_W'(DAC_WIDTH - 1);
                    first_d = 1'b1;
                    if (pick_ch != ch_sel_q) begin
                        ch_sel_d = pick_ch;
                        cnt_d    = CNT_W'(MUX_SETTLE_CYCLES - 1);
                        state_d  = ST_MUX_SETTLE;
                    end else begin
                        state_d = ST_SET_CODE;
                    end
                end
            end
            ST_MUX_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SET_CODE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SET_CODE: begin
                if (mode_q == MODE_SAR) begin
                    dac_code_d = acc_q | (DAC_WIDTH'(1) << bit_q);
                end else begin
                    dac_code_d = first_q ? '0 : dac_code_q + DAC_WIDTH'(1);
                end
                first_d = 1'b0;
                cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_DECIDE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DECIDE: begin
                if (mode_q == MODE_SAR) begin
                    // compare=1 means the trial overshot: drop the trial bit.
                    acc_next = cmp_s ? acc_q : dac_code_q;
                    acc_d    = acc_next;
                    if (bit_q == '0) begin
                        fin      = 1'b1;
                        fin_data = acc_next;
                        fin_ovr  = (acc_next == '1) && !cmp_s;
                    end else begin
                        bit_d   = bit_q - BIT_W'(1);
                        state_d = ST_SET_CODE;
                    end
                end else begin
                    if (cmp_s) begin
                        fin      = 1'b1;
                        fin_data = (dac_code_q == '0) ? '0 : dac_code_q - DAC_WIDTH'(1);
                    end else if (dac_code_q == '1) begin
                        fin      = 1'b1;
                        fin_data = '1;
                        fin_ovr  = 1'b1;
                    end else begin
                        state_d = ST_SET_CODE;
                    end
                end
            end
            ST_DONE: begin
                ptr_d   = (ch_sel_q == CH_W'(NUM_CH - 1)) ? '0 : ch_sel_q + CH_W'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fin) begin
            result_data_d  = fin_data;
            result_ch_d    = ch_sel_q;
            overrange_d    = fin_ovr;
            result_valid_d = 1'b1;
            dac_code_d     = '0;
            state_d        = ST_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            dac_code_q     <= '0;
            acc_q          <= '0;
            bit_q          <= '0;
            first_q        <= 1'b0;
            mode_q         <= MODE_RAMP;
            ch_sel_q       <= '0;
            ptr_q          <= '0;
            result_data_q  <= '0;
            result_ch_q    <= '0;
            overrange_q    <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dac_code_q     <= dac_code_d;
            acc_q          <= acc_d;
            bit_q          <= bit_d;
            first_q        <= first_d;
            mode_q         <= mode_d;
            ch_sel_q       <= ch_sel_d;
            ptr_q          <= ptr_d;
            result_data_q  <= result_data_d;
            result_ch_q    <= result_ch_d;
            overrange_q    <= overrange_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign dac_code     = dac_code_q;
    assign ch_sel       = ch_sel_q;
    assign result_data  = result_data_q;
    assign result_ch    = result_ch_q;
    assign overrange    = overrange_q;
    assign result_valid = result_valid_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: doc/adc_scan_engine.md
Name: adc_scan_engine

Overview:
- Parametrised, time-multiplexed successor to the separate PWM and R2R ramp/SAR converters.
- One DAC code bus and one comparator serve NUM_CH analog channels through an external analog mux (ch_sel).
- Each channel converts in ramp or SAR mode, selected per channel. Results stream out with a valid pulse and channel tag.
- Feeds the averaging/scaling path and the menu subsystem.

Parameters:
DAC_WIDTH, 8, DAC code and result width
NUM_CH, 2, number of multiplexed channels (1..16)
SETTLE_CYCLES, 1000, clk cycles waited after each DAC update (must be >= SYNC_STAGES+1)
MUX_SETTLE_CYCLES, 2000, extra wait after ch_sel changes
SYNC_STAGES, 2, comparator synchroniser depth

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run scanning; low = stop after current conversion
ch_enable  in  NUM_CH  per-channel scan mask
sar_mode  in  NUM_CH  per-channel mode: 0 = ramp, 1 = SAR
compare  in  1  async comparator; 1 = DAC voltage > input
dac_code  out  DAC_WIDTH  code to R2R/PWM DAC
ch_sel  out  CH_W  analog mux select; CH_W = max(1, clog2(NUM_CH))
result_data  out  DAC_WIDTH  converted code
result_ch  out  CH_W  channel of result_data
result_valid  out  1  one-cycle pulse per completed conversion
overrange  out  1  qualifies result_valid: input >= full scale
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0; FSM enters IDLE; synchroniser flushed to 0; scan pointer set to channel 0.
- compare passes through SYNC_STAGES flops before use. The settle wait absorbs this latency.
- FSM states: IDLE, MUX_SETTLE, SET_CODE, SETTLE, DECIDE, DONE.
- IDLE:
  - Leaves when enable=1 and ch_enable != 0.
  - Picks the next enabled channel, round-robin from the channel after the last converted one.
  - Latches that channel's sar_mode bit. Mode changes mid-conversion are ignored.
  - If the picked channel differs from the current ch_sel: update ch_sel, go to MUX_SETTLE. Otherwise go to SET_CODE.
  - With ch_enable = 0, stays in IDLE with busy=0.
- MUX_SETTLE: waits MUX_SETTLE_CYCLES, then SET_CODE.
- SET_CODE (1 cycle) drives the trial code:
  - Ramp: 0 on the first step, otherwise previous code + 1.
  - SAR: the accumulated code with the current trial bit set, starting at the MSB.
- SETTLE: waits SETTLE_CYCLES.
- DECIDE (1 cycle) samples the synchronised compare:
  - Ramp, compare=1: result = code-1, saturating at 0; go to DONE.
  - Ramp, compare=0 at code = all-ones: result = all-ones, overrange=1; go to DONE.
  - Ramp, otherwise: go to SET_CODE.
  - SAR, compare=1: clear the trial bit; compare=0: keep it.
  - SAR, after the LSB: result = code; overrange=1 if result is all-ones and the final compare was 0; go to DONE.
  - SAR, otherwise: move to the next lower bit, go to SET_CODE.
- Step cost: one step is SETTLE_CYCLES+2 cycles. SAR takes exactly DAC_WIDTH steps; ramp takes (trip code + 1) steps.
- DONE (1 cycle):
  - result_data, result_ch and overrange register here; result_valid=1 for this cycle only.
  - dac_code returns to 0.
  - Then IDLE. IDLE re-launches on the next cycle if enable is still 1.
- Stopping: enable falling mid-conversion does not abort; the engine completes to DONE, then holds in IDLE.
- ch_enable for the in-flight channel cleared mid-conversion: the conversion still completes.
- result_data/result_ch/overrange hold their values between pulses.
- Reset asserted mid-conversion: abort immediately to reset values; no result_valid.
- NUM_CH=1: ch_sel is constant 0 and MUX_SETTLE is never entered after the first conversion.

Decomposition:
- Package adc_scan_pkg: state enum typedef, CH_W function/constant, mode encodings (MODE_RAMP=0, MODE_SAR=1).
- One sub-module: cmp_sync (parametrised SYNC_STAGES flop chain, reset to 0).
- Counters and FSM live in adc_scan_engine.
- The existing PWM and R2R subsystems instantiate this engine and drive their DAC from dac_code.

Test Plan:
Use DAC_WIDTH=4, NUM_CH=2, SETTLE_CYCLES=3, MUX_SETTLE_CYCLES=4, SYNC_STAGES=2. Model compare = (dac_code > vin[ch_sel]) with a 1-cycle analog delay.
- SAR ch0, vin=9: trials 8, 12, 10, 9 -> result_data=9, result_ch=0, overrange=0. result_valid fires exactly 20 cycles after SET_CODE entry (4 steps × 5), plus the mux wait when ch_sel changes.
- Ramp ch1, vin=9: trip at code 10 -> result_data=9, result_ch=1. 11 steps = 55 cycles from first SET_CODE to DONE.
- Overrange: SAR vin=15 -> result 15, overrange=1; SAR vin=14 -> result 14, overrange=0; ramp vin=15 -> result 15, overrange=1; ramp vin=0 -> trips at code 1, result 0, overrange=0.
- Scan order: ch_enable=2'b11, modes 2'b01 -> alternating results ch0, ch1, ch0…; mux wait appears before each conversion. ch_enable=2'b10 -> only ch1 results, no MUX_SETTLE after the first conversion.
- Drop enable mid-SAR -> that conversion completes with one result_valid pulse, then busy=0 and dac_code=0. Toggle sar_mode mid-conversion -> no effect until the next conversion.
- Assert reset during SETTLE -> next cycle all outputs 0, no result_valid. After release with enable=1, a conversion restarts from channel 0.
